// File: rtl/clock_divider_bank_if.sv
// Configuration and status bundle shared between clock_divider_bank and its controller.
interface clock_divider_bank_if #(
   parameter int NUM_CH = 8,
   parameter int DIV_W  = 8
);
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic              cfg_valid;
   logic              cfg_ready;
   logic [CH_W-1:0]   cfg_ch;
   logic [DIV_W-1:0]  cfg_div;
   logic              cfg_en;
   logic              sync_req;
   logic [NUM_CH-1:0] clk_out;
   logic [NUM_CH-1:0] clk_tick;
   logic [NUM_CH-1:0] clk_valid;
   logic              cfg_err;

   modport master (
      output cfg_valid, cfg_ch, cfg_div, cfg_en, sync_req,
      input  cfg_ready, clk_out, clk_tick, clk_valid, cfg_err
   );

   modport slave (
      input  cfg_valid, cfg_ch, cfg_div, cfg_en, sync_req,
      output cfg_ready, clk_out, clk_tick, clk_valid, cfg_err
   );
endinterface

// File: rtl/clock_divider_bank.sv
// Bank of independent integer clock dividers with glitch-free ratio changes,
// per-channel stability qualification and a global phase realign.
//
// state  | meaning
// ST_OFF | channel stopped, clk_out low, never holds a pending request
// ST_RUN | counter cycling 0..D-1, shadow request applied only at wrap or sync
module clock_divider_bank #(
   parameter int NUM_CH         = 8,
   parameter int DIV_W          = 8,
   parameter int STABLE_PERIODS = 4
) (
   input  logic                ref_clk,
   input  logic                rst,
   clock_divider_bank_if.slave bus
);
   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int STB_W = $clog2(STABLE_PERIODS + 1);

   typedef enum logic {ST_OFF = 1'b0, ST_RUN = 1'b1} ch_state_t;

   logic              w_hs;
   logic              w_illegal;
   logic              w_legal_hs;
   logic [NUM_CH-1:0] w_pend;
   logic [NUM_CH-1:0] w_out;
   logic [NUM_CH-1:0] w_tick;
   logic [NUM_CH-1:0] w_valid;
   logic              r_err;

   assign bus.cfg_ready = !w_pend[bus.cfg_ch];
   assign w_hs          = bus.cfg_valid && bus.cfg_ready;
   assign w_illegal     = bus.cfg_en && (bus.cfg_div < DIV_W'(2));
   assign w_legal_hs    = w_hs && !w_illegal;

   always_ff @(posedge ref_clk or posedge rst) begin
      if (rst) r_err <= 1'b0;
      else     r_err <= w_hs && w_illegal;
   end

   assign bus.cfg_err   = r_err;
   assign bus.clk_out   = w_out;
   assign bus.clk_tick  = w_tick;
   assign bus.clk_valid = w_valid;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      ch_state_t        r_state, w_state_nx;
      logic [DIV_W-1:0] r_d, w_d_nx;
      logic [DIV_W-1:0] r_cnt, w_cnt_nx, w_cnt_inc;
      logic [DIV_W-1:0] r_sh_d, w_sh_d_nx;
      logic             r_sh_en, w_sh_en_nx;
      logic             r_pend, w_pend_nx;
      logic [STB_W-1:0] r_stab, w_stab_nx;
      logic             r_out, w_out_nx;
      logic             r_tick, w_tick_nx;
      logic             r_valid;
      logic             w_sel, w_wrap, w_req, w_req_en;
      logic [DIV_W-1:0] w_req_d;
      logic [DIV_W:0]   w_half;

      assign w_sel     = w_legal_hs && (bus.cfg_ch == CH_W'(g));
      assign w_wrap    = (r_cnt == r_d - DIV_W'(1));
      assign w_cnt_inc = r_cnt + DIV_W'(1);
      assign w_half    = ({1'b0, r_d} + (DIV_W+1)'(1)) >> 1;
      // A request accepted on the boundary edge itself is applied without a pending stop.
      assign w_req     = r_pend || w_sel;
      assign w_req_d   = r_pend ? r_sh_d  : bus.cfg_div;
      assign w_req_en  = r_pend ? r_sh_en : bus.cfg_en;

      always_comb begin
         w_state_nx = r_state;
         w_d_nx     = r_d;
         w_cnt_nx   = r_cnt;
         w_sh_d_nx  = r_sh_d;
         w_sh_en_nx = r_sh_en;
         w_pend_nx  = r_pend;
         w_stab_nx  = r_stab;
         w_out_nx   = r_out;
         w_tick_nx  = 1'b0;
         case (r_state)
            ST_OFF: begin
               if (w_sel && bus.cfg_en) begin
                  w_state_nx = ST_RUN;
                  w_d_nx     = bus.cfg_div;
                  w_cnt_nx   = '0;
                  w_stab_nx  = '0;
                  w_out_nx   = 1'b1;
                  w_tick_nx  = 1'b1;
               end
            end
            ST_RUN: begin
               if (bus.sync_req || w_wrap) begin
                  w_cnt_nx  = '0;
                  w_pend_nx = 1'b0;
                  if (w_req && !w_req_en) begin
                     w_state_nx = ST_OFF;
                     w_stab_nx  = '0;
                     w_out_nx   = 1'b0;
                  end else begin
                     w_out_nx  = 1'b1;
                     w_tick_nx = 1'b1;
                     if (w_req) w_d_nx = w_req_d;
                     if (bus.sync_req || w_req)
                        w_stab_nx = '0;
                     else if (r_stab != STB_W'(STABLE_PERIODS))
                        w_stab_nx = r_stab + STB_W'(1);
                  end
               end else begin
                  w_cnt_nx = w_cnt_inc;
                  w_out_nx = ({1'b0, w_cnt_inc} < w_half);
                  if (w_sel) begin
                     w_sh_d_nx  = bus.cfg_div;
                     w_sh_en_nx = bus.cfg_en;
                     w_pend_nx  = 1'b1;
                  end
               end
            end
         endcase
      end

      always_ff @(posedge ref_clk or posedge rst) begin
         if (rst) begin
            r_state <= ST_OFF;
            r_d     <= '0;
            r_cnt   <= '0;
            r_sh_d  <= '0;
            r_sh_en <= 1'b0;
            r_pend  <= 1'b0;
            r_stab  <= '0;
            r_out   <= 1'b0;
            r_tick  <= 1'b0;
            r_valid <= 1'b0;
         end else begin
            r_state <= w_state_nx;
            r_d     <= w_d_nx;
            r_cnt   <= w_cnt_nx;
            r_sh_d  <= w_sh_d_nx;
            r_sh_en <= w_sh_en_nx;
            r_pend  <= w_pend_nx;
            r_stab  <= w_stab_nx;
            r_out   <= w_out_nx;
            r_tick  <= w_tick_nx;
            r_valid <= (w_stab_nx == STB_W'(STABLE_PERIODS));
         end
      end

      assign w_pend[g]  = r_pend;
      assign w_out[g]   = r_out;
      assign w_tick[g]  = r_tick;
      assign w_valid[g] = r_valid;
   end
endmodule

// File: tb/tb_clock_divider_bank.sv
// Bench for clock_divider_bank: directed scenarios plus random traffic against a period-level model.
module tb_clock_divider_bank;
   localparam int NUM_CH = 8;
   localparam int DIV_W  = 8;
   localparam int STABLE = 4;
   localparam int CH_W   = $clog2(NUM_CH);
   localparam int VW     = 3*NUM_CH + 1;

   logic ref_clk = 1'b0;
   logic rst     = 1'b1;
   always #5 ref_clk = ~ref_clk;

   clock_divider_bank_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) bus();

   clock_divider_bank #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .STABLE_PERIODS(STABLE)) dut (
      .ref_clk(ref_clk),
      .rst    (rst),
      .bus    (bus)
   );

   // Model: each running channel has a ratio, a position within its period,
   // a count of completed periods and at most one waiting request.
   int m_run [NUM_CH];
   int m_d   [NUM_CH];
   int m_ph  [NUM_CH];
   int m_done[NUM_CH];
   int m_pend[NUM_CH];
   int m_pd  [NUM_CH];
   int m_pe  [NUM_CH];
   int m_err;
   int n_checks = 0;
   int n_pass   = 0;

   task automatic model_update();
      bit hs, ill, rq, bnd;
      if (rst) begin
         for (int c = 0; c < NUM_CH; c++) begin
            m_run[c] = 0; m_d[c] = 0; m_ph[c] = 0; m_done[c] = 0;
            m_pend[c] = 0; m_pd[c] = 0; m_pe[c] = 0;
         end
         m_err = 0;
         return;
      end
      hs    = bus.cfg_valid && (m_pend[bus.cfg_ch] == 0);
      ill   = bus.cfg_en && (bus.cfg_div < 2);
      m_err = (hs && ill) ? 1 : 0;
      for (int c = 0; c < NUM_CH; c++) begin
         rq = hs && !ill && (int'(bus.cfg_ch) == c);
         if (m_run[c] == 0) begin
            if (rq && bus.cfg_en) begin
               m_run[c] = 1; m_d[c] = int'(bus.cfg_div); m_ph[c] = 0; m_done[c] = 0;
            end
         end else begin
            bnd = bus.sync_req || (m_ph[c] == m_d[c] - 1);
            if (rq) begin
               m_pend[c] = 1; m_pd[c] = int'(bus.cfg_div); m_pe[c] = int'(bus.cfg_en);
            end
            if (!bnd) m_ph[c]++;
            else begin
               m_ph[c] = 0;
               if (m_pend[c] != 0) begin
                  m_pend[c] = 0;
                  m_done[c] = 0;
                  if (m_pe[c] != 0) m_d[c] = m_pd[c];
                  else              m_run[c] = 0;
               end else if (bus.sync_req) m_done[c] = 0;
               else if (m_done[c] < STABLE) m_done[c]++;
            end
         end
      end
   endtask

   function automatic logic [VW-1:0] exp_vec();
      logic [NUM_CH-1:0] o, t, v;
      for (int c = 0; c < NUM_CH; c++) begin
         o[c] = (m_run[c] != 0) && (m_ph[c] < (m_d[c] + 1) / 2);
         t[c] = (m_run[c] != 0) && (m_ph[c] == 0);
         v[c] = (m_run[c] != 0) && (m_done[c] == STABLE);
      end
      return {o, t, v, (m_err != 0)};
   endfunction

   function automatic logic [VW-1:0] dut_vec();
      return {bus.clk_out, bus.clk_tick, bus.clk_valid, bus.cfg_err};
   endfunction

   // Advance one clock, update the model and score every registered output.
   task automatic step();
      @(posedge ref_clk);
      model_update();
      #1;
      n_checks++;
      if (dut_vec() !== exp_vec())
         $display("FAIL scoreboard @%0t: got %h want %h", $time, dut_vec(), exp_vec());
      else n_pass++;
   endtask

   task automatic drive_cfg(input int ch, input int div, input bit en);
      bus.cfg_valid = 1'b1;
      bus.cfg_ch    = CH_W'(ch);
      bus.cfg_div   = DIV_W'(div);
      bus.cfg_en    = en;
   endtask

   task automatic idle();
      bus.cfg_valid = 1'b0;
      bus.sync_req  = 1'b0;
   endtask

   task automatic test_reset();
      for (int k = 0; k < 3; k++) step();
      n_checks++;
      if (dut_vec() !== '0) $display("FAIL reset_outputs: got %h want 0", dut_vec());
      else n_pass++;
      for (int c = 0; c < NUM_CH; c++) begin
         bus.cfg_ch = CH_W'(c);
         step();
         n_checks++;
         if (bus.cfg_ready !== 1'b1) $display("FAIL reset_ready ch%0d: got %b want 1", c, bus.cfg_ready);
         else n_pass++;
      end
      rst = 1'b0;
      for (int k = 0; k < 5; k++) step();
      n_checks++;
      if (dut_vec() !== '0) $display("FAIL reset_quiet: got %h want 0", dut_vec());
      else n_pass++;
   endtask

   task automatic test_start();
      drive_cfg(0, 4, 1'b1);
      #1;
      n_checks++;
      if (bus.cfg_ready !== 1'b1) $display("FAIL start_ready: got %b want 1", bus.cfg_ready);
      else n_pass++;
      step();
      idle();
      for (int j = 1; j <= 20; j++) begin
         if (j > 1) step();
         n_checks++;
         if (bus.clk_out[0] !== (((j-1) % 4) < 2) || bus.clk_tick[0] !== (((j-1) % 4) == 0) ||
             bus.clk_valid[0] !== (j >= 17))
            $display("FAIL start j=%0d: got out/tick/valid %b%b%b want %b%b%b", j, bus.clk_out[0],
                     bus.clk_tick[0], bus.clk_valid[0], ((j-1) % 4) < 2, ((j-1) % 4) == 0, j >= 17);
         else n_pass++;
      end
   endtask

   task automatic test_ratio_change();
      for (int k = 0; k < 8 && m_ph[0] != 1; k++) step();
      drive_cfg(0, 6, 1'b1);
      step();
      idle();
      for (int j = 1; j <= 30; j++) begin
         if (j > 1) step();
         n_checks++;
         if (bus.clk_out[0] !== (j >= 3 && ((j-3) % 6) < 3) ||
             bus.clk_tick[0] !== (j >= 3 && ((j-3) % 6) == 0) ||
             bus.clk_valid[0] !== (j < 3 || j >= 27) || bus.cfg_ready !== (j >= 3))
            $display("FAIL ratio j=%0d: got out/tick/valid/ready %b%b%b%b want %b%b%b%b", j,
                     bus.clk_out[0], bus.clk_tick[0], bus.clk_valid[0], bus.cfg_ready,
                     j >= 3 && ((j-3) % 6) < 3, j >= 3 && ((j-3) % 6) == 0, j < 3 || j >= 27, j >= 3);
         else n_pass++;
      end
   endtask

   task automatic test_disable();
      drive_cfg(2, 5, 1'b1);
      step();
      idle();
      for (int k = 0; k < 10 && m_ph[2] != 2; k++) step();
      drive_cfg(2, 5, 1'b0);
      step();
      idle();
      drive_cfg(2, 7, 1'b1);
      #1;
      n_checks++;
      if (bus.cfg_ready !== 1'b0) $display("FAIL disable_blocked: got ready %b want 0", bus.cfg_ready);
      else n_pass++;
      for (int j = 1; j <= 10; j++) begin
         if (j == 2) idle();
         if (j > 1) step();
         n_checks++;
         if (bus.clk_out[2] !== 1'b0 || bus.clk_tick[2] !== 1'b0 || (j >= 3 && bus.cfg_ready !== 1'b1))
            $display("FAIL disable j=%0d: got out/tick/ready %b%b%b want 00%b", j, bus.clk_out[2],
                     bus.clk_tick[2], bus.cfg_ready, j >= 3);
         else n_pass++;
      end
   endtask

   task automatic test_illegal();
      for (int div = 1; div >= 0; div--) begin
         drive_cfg(1, div, 1'b1);
         step();
         idle();
         n_checks++;
         if (bus.cfg_err !== 1'b1 || bus.clk_out[1] !== 1'b0 || bus.clk_tick[1] !== 1'b0)
            $display("FAIL illegal_div%0d: got err/out/tick %b%b%b want 100", div, bus.cfg_err,
                     bus.clk_out[1], bus.clk_tick[1]);
         else n_pass++;
         step();
         n_checks++;
         if (bus.cfg_err !== 1'b0 || bus.cfg_ready !== 1'b1 || bus.clk_out[1] !== 1'b0)
            $display("FAIL illegal_after_div%0d: got err/ready/out %b%b%b want 010", div, bus.cfg_err,
                     bus.cfg_ready, bus.clk_out[1]);
         else n_pass++;
      end
      drive_cfg(0, 0, 1'b1);
      step();
      idle();
      n_checks++;
      if (bus.cfg_err !== 1'b1 || bus.cfg_ready !== 1'b1)
         $display("FAIL illegal_running: got err/ready %b%b want 11", bus.cfg_err, bus.cfg_ready);
      else n_pass++;
      drive_cfg(3, 0, 1'b0);
      step();
      idle();
      step();
      n_checks++;
      if (bus.cfg_err !== 1'b0 || bus.clk_out[3] !== 1'b0 || bus.clk_tick[3] !== 1'b0)
         $display("FAIL off_disable: got err/out/tick %b%b%b want 000", bus.cfg_err, bus.clk_out[3],
                  bus.clk_tick[3]);
      else n_pass++;
   endtask

   task automatic test_sync();
      drive_cfg(0, 4, 1'b1);
      step();
      idle();
      for (int k = 0; k < 10 && m_pend[0] != 0; k++) step();
      for (int k = 0; k < 3; k++) step();
      drive_cfg(1, 6, 1'b1);
      step();
      idle();
      for (int k = 0; k < 2; k++) step();
      bus.sync_req = 1'b1;
      step();
      idle();
      for (int j = 1; j <= 25; j++) begin
         if (j > 1) step();
         n_checks++;
         if (bus.clk_tick[0] !== (((j-1) % 4) == 0) || bus.clk_tick[1] !== (((j-1) % 6) == 0) ||
             bus.clk_valid[0] !== (j >= 17) || bus.clk_valid[1] !== (j >= 25))
            $display("FAIL sync j=%0d: got tick/valid %b%b/%b%b want %b%b/%b%b", j, bus.clk_tick[0],
                     bus.clk_tick[1], bus.clk_valid[0], bus.clk_valid[1], ((j-1) % 4) == 0,
                     ((j-1) % 6) == 0, j >= 17, j >= 25);
         else n_pass++;
      end
      drive_cfg(0, 3, 1'b1);
      bus.sync_req = 1'b1;
      step();
      idle();
      for (int j = 1; j <= 9; j++) begin
         if (j > 1) step();
         n_checks++;
         if (bus.clk_out[0] !== (((j-1) % 3) < 2) || bus.clk_tick[0] !== (((j-1) % 3) == 0) ||
             bus.cfg_ready !== 1'b1 || (j == 1 && bus.clk_tick[1] !== 1'b1))
            $display("FAIL sync_apply j=%0d: got out/tick/ready %b%b%b want %b%b1", j, bus.clk_out[0],
                     bus.clk_tick[0], bus.cfg_ready, ((j-1) % 3) < 2, ((j-1) % 3) == 0);
         else n_pass++;
      end
   endtask

   task automatic test_reset_midperiod();
      for (int k = 0; k < 6 && m_ph[0] != 0; k++) step();
      drive_cfg(0, 5, 1'b1);
      step();
      idle();
      n_checks++;
      if (bus.clk_out[0] !== 1'b1 || bus.cfg_ready !== 1'b0)
         $display("FAIL rstmid_pre: got out/ready %b%b want 10", bus.clk_out[0], bus.cfg_ready);
      else n_pass++;
      #3;
      rst = 1'b1;
      #1;
      model_update();
      n_checks++;
      if (dut_vec() !== '0 || bus.cfg_ready !== 1'b1)
         $display("FAIL rstmid_async: got %h ready %b want 0 ready 1", dut_vec(), bus.cfg_ready);
      else n_pass++;
      step();
      step();
      #2;
      rst = 1'b0;
      for (int k = 0; k < 6; k++) step();
      n_checks++;
      if (dut_vec() !== '0) $display("FAIL rstmid_quiet: got %h want 0", dut_vec());
      else n_pass++;
      drive_cfg(0, 2, 1'b1);
      step();
      idle();
      for (int j = 1; j <= 8; j++) begin
         if (j > 1) step();
         n_checks++;
         if (bus.clk_out[0] !== (((j-1) % 2) == 0) || bus.clk_tick[0] !== (((j-1) % 2) == 0))
            $display("FAIL rstmid_div2 j=%0d: got out/tick %b%b want %b%b", j, bus.clk_out[0],
                     bus.clk_tick[0], ((j-1) % 2) == 0, ((j-1) % 2) == 0);
         else n_pass++;
      end
   endtask

   task automatic test_random();
      int r, ch, div;
      for (int i = 0; i < 600; i++) begin
         ch = $urandom_range(0, NUM_CH-1);
         r  = $urandom_range(0, 9);
         if (r < 2)       div = $urandom_range(0, 2);
         else if (r == 9) div = $urandom_range(250, 255);
         else             div = $urandom_range(2, 12);
         drive_cfg(ch, div, ($urandom_range(0, 4) != 0));
         bus.cfg_valid = ($urandom_range(0, 2) == 0);
         bus.sync_req  = ($urandom_range(0, 29) == 0);
         #1;
         n_checks++;
         if (bus.cfg_ready !== (m_pend[ch] == 0))
            $display("FAIL random_ready ch%0d: got %b want %b", ch, bus.cfg_ready, m_pend[ch] == 0);
         else n_pass++;
         step();
      end
      idle();
      step();
   endtask

   initial begin
      bus.cfg_valid = 1'b0;
      bus.cfg_ch    = '0;
      bus.cfg_div   = '0;
      bus.cfg_en    = 1'b0;
      bus.sync_req  = 1'b0;
      model_update();
      test_reset();
      test_start();
      test_ratio_change();
      test_disable();
      test_illegal();
      test_sync();
      test_reset_midperiod();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end
endmodule
